pcu_i2c_sequencer: RTL and testbench
====================================

# pcu_i2c_sequencer

Transaction sequencer between the PCU's SPI slave byte interface and its I2C master engine. It parses SPI frames into I2C write or read requests, drives the I2C master enable/ready handshake, and returns read data or status to the SPI slave's transmit path. It replaces ad-hoc enable toggling with a single deterministic state machine, timeout supervision and error reporting.

## Interface
- TIMEOUT_CYCLES, 4096: max i_Clk cycles allowed in each I2C wait state before abort (legal range 16..65535)
- i_Clk  in  1  system clock; all logic on rising edge
- i_Rst_L  in  1  reset, synchronous, active-low (one clock; reset is synchronous and active-low)
- i_CS_n  in  1  SPI chip select from host, active-low; frame boundary
- i_SPI_RX_DV  in  1  one-cycle pulse, byte received on MOSI
- i_SPI_RX_Byte  in  8  received byte, valid with i_SPI_RX_DV
- o_SPI_TX_DV  out  1  one-cycle pulse loading o_SPI_TX_Byte into SPI slave
- o_SPI_TX_Byte  out  8  read data or status byte for next SPI frame
- o_I2C_Enable  out  1  request to I2C master, level, held until accepted
- o_I2C_Addr  out  7  7-bit target address
- o_I2C_RW  out  1  1 = read, 0 = write
- o_I2C_Data  out  8  write data
- i_I2C_Ready  in  1  I2C master idle (high) / busy (low)
- i_I2C_RX_DV  in  1  one-cycle pulse, read byte valid
- i_I2C_RX_Byte  in  8  byte read from target
- i_I2C_Nack  in  1  one-cycle pulse, target NACKed address or data
- o_Busy  out  1  high in any state other than IDLE
- o_Err  out  1  sticky: timeout or NACK; cleared by reset or next accepted command byte

## Operation
- Frame format: byte0 = {addr[6:0], rw}. Write (rw=0): byte1 = data. Read (rw=1): byte0 only.
- States: IDLE, GET_DATA, ISSUE, WAIT_ACCEPT, WAIT_DONE, RESP.
- IDLE: i_SPI_RX_DV with i_CS_n=0 latches byte0 into o_I2C_Addr/o_I2C_RW and clears o_Err. Goes to GET_DATA if rw=0, ISSUE if rw=1.
- GET_DATA: next i_SPI_RX_DV latches o_I2C_Data and goes to ISSUE. i_CS_n=1 before byte1 aborts to IDLE; no I2C activity and o_Err unchanged.
- ISSUE: requires i_I2C_Ready=1. Sets o_I2C_Enable=1 and goes to WAIT_ACCEPT. If Ready=0, stays in ISSUE under the timeout counter.
- WAIT_ACCEPT: o_I2C_Enable held at 1 until i_I2C_Ready=0 is sampled. Then Enable drops to 0 the next cycle and the state goes to WAIT_DONE.
- WAIT_DONE: i_I2C_RX_DV captures i_I2C_RX_Byte. i_I2C_Nack sets a nack flag. Completion is i_I2C_Ready returning to 1; go to RESP.
- RESP: one-cycle o_SPI_TX_DV, then IDLE.
  - Read without NACK: TX byte = captured read byte.
  - Otherwise TX byte = status {5'b0, rw, timeout, nack}.
  - o_Err |= nack | timeout.
- Timeout: a 16-bit counter clears on each state entry and increments in ISSUE, WAIT_ACCEPT and WAIT_DONE. Reaching TIMEOUT_CYCLES-1 sets the timeout flag, forces o_I2C_Enable=0 and goes to RESP.
- SPI bytes arriving outside IDLE and GET_DATA are dropped. No queueing.
- i_CS_n changes outside GET_DATA have no effect, so an in-flight I2C transaction always completes or times out.

## Timing
- Reset (i_Rst_L=0 at a clock edge): state=IDLE, all outputs 0, flags and counter cleared. This is effective mid-transaction: Enable drops on the next edge.
- Byte0 (read) DV at cycle N: o_I2C_Enable=1 at N+2 if Ready=1.
- Byte1 (write) DV at cycle N: o_I2C_Enable=1 at N+2 if Ready=1.
- Ready low sampled at cycle M: Enable=0 at M+1.
- Ready high sampled in WAIT_DONE at cycle K: o_SPI_TX_DV=1 at K+1, o_Busy=0 at K+2.
- Simultaneous i_I2C_RX_DV and completion in the same cycle: the byte is captured and used.
- Simultaneous i_I2C_Nack and completion: the NACK is counted.
- o_I2C_Addr/RW/Data remain stable from latch until the next accepted byte0.

## Test plan
- Write: CS low, bytes 0xA0, 0xB1; I2C model takes Ready low for 40 cycles. Required: Addr=0x50, RW=0, Data=0xB1, Enable high from byte1 DV+2 until 1 cycle after Ready falls. TX byte=0x00 with TX_DV pulse, o_Err=0.
- Read: byte 0xA1; model returns 0x5A via RX_DV. Required: RW=1, o_SPI_TX_Byte=0x5A with a single TX_DV pulse, o_Busy low 2 cycles after Ready rises.
- NACK: write 0xA0/0x2A; model pulses i_I2C_Nack. Required: TX byte=0x01, o_Err=1. The next byte0 clears o_Err.
- Timeout: TIMEOUT_CYCLES=64; model holds Ready=0 forever after accept. Required: WAIT_DONE exits after 64 cycles, Enable=0, TX byte=0x02, o_Err=1.
- Abort: byte 0xA0 then CS high with no byte1. Required: return to IDLE, Enable never asserted, o_Busy=0.
- Reset mid-op: i_Rst_L low during WAIT_ACCEPT. Required: all outputs 0 one edge later. A subsequent write 0xA0/0xB1 completes normally.

Source files
------------

// File: rtl/pcu_i2c_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pcu_i2c_sequencer_if
// Brief    : SPI-byte / I2C-engine bundle seen by the PCU I2C sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pcu_i2c_sequencer_if;
    logic       i_CS_n;
    logic       i_SPI_RX_DV;
    logic [7:0] i_SPI_RX_Byte;
    logic       o_SPI_TX_DV;
    logic [7:0] o_SPI_TX_Byte;
    logic       o_I2C_Enable;
    logic [6:0] o_I2C_Addr;
    logic       o_I2C_RW;
    logic [7:0] o_I2C_Data;
    logic       i_I2C_Ready;
    logic       i_I2C_RX_DV;
    logic [7:0] i_I2C_RX_Byte;
    logic       i_I2C_Nack;
    logic       o_Busy;
    logic       o_Err;

    // Sequencer side
    modport master (
        input  i_CS_n, i_SPI_RX_DV, i_SPI_RX_Byte,
        input  i_I2C_Ready, i_I2C_RX_DV, i_I2C_RX_Byte, i_I2C_Nack,
        output o_SPI_TX_DV, o_SPI_TX_Byte, o_I2C_Enable, o_I2C_Addr,
        output o_I2C_RW, o_I2C_Data, o_Busy, o_Err
    );

    // SPI slave / I2C engine side
    modport slave (
        output i_CS_n, i_SPI_RX_DV, i_SPI_RX_Byte,
        output i_I2C_Ready, i_I2C_RX_DV, i_I2C_RX_Byte, i_I2C_Nack,
        input  o_SPI_TX_DV, o_SPI_TX_Byte, o_I2C_Enable, o_I2C_Addr,
        input  o_I2C_RW, o_I2C_Data, o_Busy, o_Err
    );
endinterface
`default_nettype wire

// File: rtl/pcu_i2c_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pcu_i2c_sequencer
// Brief    : Parses SPI frames into I2C requests, supervises the handshake
//            with a timeout and returns read data or status to the SPI side.
// Revision : 1.0 - initial release
// ============================================================================
module pcu_i2c_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic            i_Clk,
    input  wire logic            i_Rst_L,
    pcu_i2c_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_GET_DATA    = 3'd1,
        S_ISSUE       = 3'd2,
        S_WAIT_ACCEPT = 3'd3,
        S_WAIT_DONE   = 3'd4,
        S_RESP        = 3'd5
    } state_t;

    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state,   w_state;
    logic [15:0] r_cnt,     w_cnt;
    logic [6:0]  r_addr,    w_addr;
    logic        r_rw,      w_rw;
    logic [7:0]  r_data,    w_data;
    logic        r_en,      w_en;
    logic [7:0]  r_rd_byte, w_rd_byte;
    logic        r_nack,    w_nack;
    logic        r_tout,    w_tout;
    logic        r_err,     w_err;
    logic        r_tx_dv,   w_tx_dv;
    logic [7:0]  r_tx_byte, w_tx_byte;
    logic        w_last;

    assign w_last = (r_cnt == c_TO_LAST);

    always_comb begin
        w_state   = r_state;
        w_cnt     = 16'd0;
        w_addr    = r_addr;
        w_rw      = r_rw;
        w_data    = r_data;
        w_en      = r_en;
        w_rd_byte = r_rd_byte;
        w_nack    = r_nack;
        w_tout    = r_tout;
        w_err     = r_err;
        w_tx_dv   = 1'b0;
        w_tx_byte = r_tx_byte;

        case (r_state)
            S_IDLE: begin
                if (bus.i_SPI_RX_DV && !bus.i_CS_n) begin
                    w_addr    = bus.i_SPI_RX_Byte[7:1];
                    w_rw      = bus.i_SPI_RX_Byte[0];
                    w_err     = 1'b0;
                    w_nack    = 1'b0;
                    w_tout    = 1'b0;
                    w_rd_byte = 8'h00;
                    w_state   = bus.i_SPI_RX_Byte[0] ? S_ISSUE : S_GET_DATA;
                end
            end
            S_GET_DATA: begin
                if (bus.i_CS_n) begin
                    w_state = S_IDLE;
                end else if (bus.i_SPI_RX_DV) begin
                    w_data  = bus.i_SPI_RX_Byte;
                    w_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cnt = r_cnt + 16'd1;
                if (bus.i_I2C_Ready) begin
                    w_en    = 1'b1;
                    w_state = S_WAIT_ACCEPT;
                end else if (w_last) begin
                    w_tout  = 1'b1;
                    w_state = S_RESP;
                end
            end
            S_WAIT_ACCEPT: begin
                w_cnt = r_cnt + 16'd1;
                if (!bus.i_I2C_Ready) begin
                    w_en    = 1'b0;
                    w_state = S_WAIT_DONE;
                end else if (w_last) begin
                    w_en    = 1'b0;
                    w_tout  = 1'b1;
                    w_state = S_RESP;
                end
            end
            S_WAIT_DONE: begin
                w_cnt = r_cnt + 16'd1;
                // Capture in the completion cycle too so a late byte/NACK is not lost
                if (bus.i_I2C_RX_DV) w_rd_byte = bus.i_I2C_RX_Byte;
                if (bus.i_I2C_Nack)  w_nack    = 1'b1;
                if (bus.i_I2C_Ready) begin
                    w_state = S_RESP;
                end else if (w_last) begin
                    w_tout  = 1'b1;
                    w_state = S_RESP;
                end
            end
            S_RESP: begin
                w_err   = r_err | r_nack | r_tout;
                w_state = S_IDLE;
            end
            default: begin
                w_en    = 1'b0;
                w_state = S_IDLE;
            end
        endcase

        if (w_state != r_state) w_cnt = 16'd0;

        // Response is loaded on entry to RESP so TX_DV is a single clean pulse
        if (w_state == S_RESP && r_state != S_RESP) begin
            w_tx_dv   = 1'b1;
            w_tx_byte = (r_rw && !w_nack && !w_tout) ? w_rd_byte
                                                      : {5'b00000, r_rw, w_tout, w_nack};
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_addr    <= 7'd0;
            r_rw      <= 1'b0;
            r_data    <= 8'd0;
            r_en      <= 1'b0;
            r_rd_byte <= 8'd0;
            r_nack    <= 1'b0;
            r_tout    <= 1'b0;
            r_err     <= 1'b0;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= 8'd0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_addr    <= w_addr;
            r_rw      <= w_rw;
            r_data    <= w_data;
            r_en      <= w_en;
            r_rd_byte <= w_rd_byte;
            r_nack    <= w_nack;
            r_tout    <= w_tout;
            r_err     <= w_err;
            r_tx_dv   <= w_tx_dv;
            r_tx_byte <= w_tx_byte;
        end
    end

    assign bus.o_SPI_TX_DV   = r_tx_dv;
    assign bus.o_SPI_TX_Byte = r_tx_byte;
    assign bus.o_I2C_Enable  = r_en;
    assign bus.o_I2C_Addr    = r_addr;
    assign bus.o_I2C_RW      = r_rw;
    assign bus.o_I2C_Data    = r_data;
    assign bus.o_Busy        = (r_state != S_IDLE);
    assign bus.o_Err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pcu_i2c_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcu_i2c_sequencer
// Brief    : Directed bench for pcu_i2c_sequencer with a cycle-timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcu_i2c_sequencer;

    localparam int c_TO = 64;

    logic clk = 1'b0;
    logic rst_l;
    int   n_total = 0;
    int   n_bad   = 0;
    bit   chk_on  = 1'b0;

    // Expected output values for the current cycle
    logic       want_busy, want_en, want_txdv, want_rw, want_err;
    logic [6:0] want_addr;
    logic [7:0] want_data, want_txb;

    pcu_i2c_sequencer_if bus ();

    pcu_i2c_sequencer #(.TIMEOUT_CYCLES(c_TO)) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_l),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy",    32'(bus.o_Busy),        32'(want_busy));
            chk("enable",  32'(bus.o_I2C_Enable),  32'(want_en));
            chk("tx_dv",   32'(bus.o_SPI_TX_DV),   32'(want_txdv));
            chk("tx_byte", 32'(bus.o_SPI_TX_Byte), 32'(want_txb));
            chk("err",     32'(bus.o_Err),         32'(want_err));
            chk("addr",    32'(bus.o_I2C_Addr),    32'(want_addr));
            chk("rw",      32'(bus.o_I2C_RW),      32'(want_rw));
            chk("data",    32'(bus.o_I2C_Data),    32'(want_data));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        bus.i_CS_n        = 1'b1;
        bus.i_SPI_RX_DV   = 1'b0;
        bus.i_SPI_RX_Byte = 8'h00;
        bus.i_I2C_Ready   = 1'b1;
        bus.i_I2C_RX_DV   = 1'b0;
        bus.i_I2C_RX_Byte = 8'h00;
        bus.i_I2C_Nack    = 1'b0;
        want_busy = 1'b0;
        want_en   = 1'b0;
        want_txdv = 1'b0;
    endtask

    // Cycle 0 carries byte0. B: last SPI byte cycle, M: Ready-low cycle,
    // K: completion cycle (Ready high, or last WAIT_DONE cycle on timeout).
    // len==0 means the engine never finishes; rst_at>=0 resets during WAIT_ACCEPT.
    task automatic run_txn(input logic [7:0] b0, input logic [7:0] b1,
                           input int gap, input int dly, input int len,
                           input int rx_at, input logic [7:0] rx_b,
                           input int nack_at, input int rst_at);
        logic       rw, nk, to;
        logic [7:0] txv;
        int         B, M, K, R, last;
        rw   = b0[0];
        nk   = (nack_at >= 0);
        to   = (len == 0);
        B    = rw ? 0 : 1 + gap;
        M    = B + 2 + dly;
        K    = to ? M + c_TO : M + len;
        R    = (rst_at >= 0) ? B + 2 + rst_at : -1;
        last = (R >= 0) ? R : K + 2;
        txv  = (rw && !nk && !to) ? rx_b : {5'b00000, rw, to, nk};
        for (int c = 0; c <= last; c++) begin
            bus.i_CS_n        = (c > B);
            bus.i_SPI_RX_DV   = (c == 0) || (!rw && c == B) || (c == M + 1);
            bus.i_SPI_RX_Byte = (c == 0) ? b0 : ((!rw && c == B) ? b1 : 8'hFF);
            bus.i_I2C_Ready   = !(c >= M && (to || c < K));
            bus.i_I2C_RX_DV   = (rx_at >= 0) && (c == M + 1 + rx_at);
            bus.i_I2C_RX_Byte = rx_b;
            bus.i_I2C_Nack    = nk && (c == M + 1 + nack_at);
            rst_l             = (c != R);
            want_busy = (c >= 1) && (c <= K + 1);
            want_en   = (c >= B + 2) && (c <= M);
            want_txdv = (c == K + 1);
            if (c == 1) begin
                want_addr = b0[7:1];
                want_rw   = rw;
                want_err  = 1'b0;
            end
            if (!rw && c == B + 1) want_data = b1;
            if (c == K + 1)        want_txb  = txv;
            if (c == K + 2)        want_err  = nk | to;
            step();
        end
        rst_l = 1'b1;
        go_idle();
        if (R >= 0) begin
            want_addr = 7'd0;
            want_rw   = 1'b0;
            want_data = 8'd0;
            want_txb  = 8'd0;
            want_err  = 1'b0;
        end
    endtask

    // byte0 of a write, then CS rises before byte1
    task automatic run_abort(input logic [7:0] b0, input int gap);
        for (int c = 0; c <= gap + 3; c++) begin
            bus.i_CS_n        = (c > gap);
            bus.i_SPI_RX_DV   = (c == 0);
            bus.i_SPI_RX_Byte = b0;
            bus.i_I2C_Ready   = 1'b1;
            want_busy = (c >= 1) && (c <= gap + 1);
            want_en   = 1'b0;
            want_txdv = 1'b0;
            if (c == 1) begin
                want_addr = b0[7:1];
                want_rw   = b0[0];
                want_err  = 1'b0;
            end
            step();
        end
        go_idle();
    endtask

    initial begin
        go_idle();
        rst_l     = 1'b0;
        want_addr = 7'd0;
        want_rw   = 1'b0;
        want_data = 8'd0;
        want_txb  = 8'd0;
        want_err  = 1'b0;
        step();
        step();
        chk("rst_enable", 32'(bus.o_I2C_Enable), 32'd0);
        chk("rst_busy",   32'(bus.o_Busy),       32'd0);
        chk("rst_txdv",   32'(bus.o_SPI_TX_DV),  32'd0);
        chk("rst_err",    32'(bus.o_Err),        32'd0);
        chk("rst_addr",   32'(bus.o_I2C_Addr),   32'd0);
        rst_l  = 1'b1;
        chk_on = 1'b1;
        step();
        step();

        // Write 0xA0 / 0xB1, engine busy for 40 cycles
        run_txn(8'hA0, 8'hB1, 2, 3, 40, -1, 8'h00, -1, -1);
        chk("wr_addr", 32'(bus.o_I2C_Addr),    32'h50);
        chk("wr_rw",   32'(bus.o_I2C_RW),      32'd0);
        chk("wr_data", 32'(bus.o_I2C_Data),    32'hB1);
        chk("wr_tx",   32'(bus.o_SPI_TX_Byte), 32'h00);
        chk("wr_err",  32'(bus.o_Err),         32'd0);
        step();

        // Read 0xA1, data 0x5A arrives in the completion cycle
        run_txn(8'hA1, 8'h00, 0, 1, 12, 11, 8'h5A, -1, -1);
        chk("rd_rw",   32'(bus.o_I2C_RW),      32'd1);
        chk("rd_tx",   32'(bus.o_SPI_TX_Byte), 32'h5A);
        chk("rd_busy", 32'(bus.o_Busy),        32'd0);
        step();

        // Write 0xA0 / 0x2A with NACK coincident with completion
        run_txn(8'hA0, 8'h2A, 0, 0, 20, -1, 8'h00, 19, -1);
        chk("nk_tx",  32'(bus.o_SPI_TX_Byte), 32'h01);
        chk("nk_err", 32'(bus.o_Err),         32'd1);
        step();

        // Abort after byte0; byte0 also clears the sticky error
        run_abort(8'hA0, 3);
        chk("ab_err",  32'(bus.o_Err),        32'd0);
        chk("ab_busy", 32'(bus.o_Busy),       32'd0);
        chk("ab_en",   32'(bus.o_I2C_Enable), 32'd0);
        step();

        // Engine never completes
        run_txn(8'hA0, 8'h77, 1, 2, 0, -1, 8'h00, -1, -1);
        chk("to_tx",  32'(bus.o_SPI_TX_Byte), 32'h02);
        chk("to_err", 32'(bus.o_Err),         32'd1);
        chk("to_en",  32'(bus.o_I2C_Enable),  32'd0);
        step();

        // Reset during WAIT_ACCEPT
        run_txn(8'hA0, 8'hB1, 1, 10, 30, -1, 8'h00, -1, 3);
        chk("mr_en",   32'(bus.o_I2C_Enable),  32'd0);
        chk("mr_busy", 32'(bus.o_Busy),        32'd0);
        chk("mr_addr", 32'(bus.o_I2C_Addr),    32'd0);
        chk("mr_data", 32'(bus.o_I2C_Data),    32'd0);
        chk("mr_tx",   32'(bus.o_SPI_TX_Byte), 32'd0);
        step();

        // Normal write after the reset
        run_txn(8'hA0, 8'hB1, 0, 0, 5, -1, 8'h00, -1, -1);
        chk("pw_addr", 32'(bus.o_I2C_Addr),    32'h50);
        chk("pw_data", 32'(bus.o_I2C_Data),    32'hB1);
        chk("pw_tx",   32'(bus.o_SPI_TX_Byte), 32'h00);
        chk("pw_err",  32'(bus.o_Err),         32'd0);
        step();
        step();

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
